// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU/loader request ports and memory bus of mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of CPU and loader ports onto one wait-stated memory
module mem_arbiter #(
  parameter int WAIT_STATES = 2,
  parameter int AW          = 8,
  parameter int DW          = 8
) (
  input  logic         clk,
  input  logic         res,
  mem_arbiter_if.slave bus
);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ldr_ack_q, ldr_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          busy_q, busy_d;
  logic          grant_ldr;

  // Owner encoding: 0 = CPU, 1 = loader. Under contention the port not served last wins.
  assign grant_ldr = bus.ldr_req && (!bus.cpu_req || !last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          owner_d  = grant_ldr;
          last_d   = grant_ldr;
          we_d     = grant_ldr ? bus.ldr_we    : bus.cpu_we;
          addr_d   = grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
          wdata_d  = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
          cnt_d    = CNT_INIT;
          mem_en_d = 1'b1;
          mem_we_d = we_d;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          cpu_ack_d = !owner_q;
          ldr_ack_d = owner_q;
          if (!we_q) begin
            if (owner_q) ldr_rdata_d = bus.mem_rdata;
            else         cpu_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d    = cnt_q - CW'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (WAIT_STATES=2 and 0 builds)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(8), .DW(8)) bus ();
  mem_arbiter_if #(.AW(8), .DW(8)) bus0 ();

  mem_arbiter #(.WAIT_STATES(2), .AW(8), .DW(8)) u_dut (.clk(clk), .res(res), .bus(bus));
  mem_arbiter #(.WAIT_STATES(0), .AW(8), .DW(8)) u_dut0 (.clk(clk), .res(res), .bus(bus0));

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit         port;
    logic [7:0] rdata;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[9];

  logic [7:0] mem[256];
  logic       init_done = 1'b0;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h5A;
      8'hFF:   return 8'hE7;
      8'h00:   return 8'h81;
      default: return a ^ 8'h3C;
    endcase
  endfunction

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus0.mem_rdata = bus0.mem_addr ^ 8'hA5;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res && init_done) begin
      check("ack_overlap", {31'd0, bus.cpu_ack && bus.ldr_ack}, 32'd0);
      check("we_without_en", {31'd0, bus.mem_we && !bus.mem_en}, 32'd0);
    end
  end

  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  // Called just before the grant edge; expects the scoreboard entry already pushed.
  task automatic wait_txn(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit perturb);
    int   ack_at = 0;
    int   en_cyc = 0;
    int   we_cyc = 0;
    exp_t s;
    @(posedge clk);
    if (perturb) begin
      #1;
      drive_port(port, 1'b0, ~we, ~addr, ~wdata);
    end
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cyc++;
        if (bus.mem_we) we_cyc++;
        check("mem_addr_hold", bus.mem_addr, addr);
        if (we) check("mem_wdata_hold", bus.mem_wdata, wdata);
      end
      if (port ? bus.ldr_ack : bus.cpu_ack) ack_at = k;
    end
    check("ack_latency", ack_at, 4);
    check("en_cycles", en_cyc, 3);
    check("we_cycles", we_cyc, we ? 3 : 0);
    if (sb.size() > 0) begin
      s = sb.pop_front();
      check("sb_rdata", port ? bus.ldr_rdata : bus.cpu_rdata, s.rdata);
    end else begin
      check("sb_empty", 32'd1, 32'd0);
    end
    @(posedge clk);
    #1;
    drive_port(port, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("ack_width", {31'd0, bus.cpu_ack | bus.ldr_ack}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] own_before;
    logic [7:0] other_before;
    own_before   = v.port ? bus.ldr_rdata : bus.cpu_rdata;
    other_before = v.port ? bus.cpu_rdata : bus.ldr_rdata;
    @(posedge clk);
    #1;
    drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    sb.push_back('{v.port, v.we ? own_before : v.exp_rdata});
    wait_txn(v.port, v.we, v.addr, v.wdata, 1'b0);
    check("other_rdata_kept", v.port ? bus.cpu_rdata : bus.ldr_rdata, other_before);
    if (v.we) check("mem_written", mem[v.addr], v.wdata);
  endtask

  initial begin
    int nack;
    int ack_at;
    int en_cyc;
    exp_t s;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'hC3, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 8'h30, 8'h11, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 8'h30, 8'h00, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hE7};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h81};
    vecs[7] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};

    drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h00; bus0.cpu_wdata = 8'h00;
    bus0.ldr_req = 1'b0; bus0.ldr_we = 1'b0; bus0.ldr_addr = 8'h00; bus0.ldr_wdata = 8'h00;

    repeat (3) @(posedge clk);
    init_done = 1'b1;
    @(negedge clk);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    check("rst_acks", {30'd0, bus.cpu_ack, bus.ldr_ack}, 32'd0);
    check("rst_rdata", {16'd0, bus.cpu_rdata, bus.ldr_rdata}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_busy0", {31'd0, bus0.busy}, 32'd0);
    res = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Request dropped and address/we changed right after the grant.
    @(posedge clk);
    #1;
    drive_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    sb.push_back('{1'b0, 8'h5A});
    wait_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b1);

    // Reset in the second ACCESS cycle of a CPU read, then the read completes after release.
    @(posedge clk);
    #1;
    drive_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    res = 1'b0;
    #1;
    check("arst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("arst_mem_addr", bus.mem_addr, 8'h00);
    check("arst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("arst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("arst_no_ack", {31'd0, bus.cpu_ack}, 32'd0);
    res = 1'b1;
    sb.push_back('{1'b0, 8'h5A});
    wait_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);

    // Both ports requesting continuously from reset: CPU first, then strict alternation.
    @(negedge clk);
    res = 1'b0;
    drive_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive_port(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    sb.push_back('{1'b0, 8'h5A});
    sb.push_back('{1'b1, 8'h81});
    sb.push_back('{1'b0, 8'h5A});
    sb.push_back('{1'b1, 8'h81});
    @(negedge clk);
    res = 1'b1;
    nack = 0;
    for (int k = 0; k < 80 && nack < 4; k++) begin
      @(negedge clk);
      if ((bus.cpu_ack || bus.ldr_ack) && sb.size() > 0) begin
        s = sb.pop_front();
        check("rr_owner", {31'd0, bus.ldr_ack}, {31'd0, s.port});
        check("rr_rdata", s.port ? bus.ldr_rdata : bus.cpu_rdata, s.rdata);
        nack++;
      end
    end
    check("rr_acks", nack, 4);
    @(posedge clk);
    #1;
    drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);

    // Zero-wait-state build: one ACCESS cycle, ack in cycle 2.
    #1;
    bus0.cpu_req = 1'b1; bus0.cpu_addr = 8'h3C; bus0.cpu_we = 1'b0;
    @(posedge clk);
    ack_at = 0;
    en_cyc = 0;
    for (int k = 1; k <= 10 && ack_at == 0; k++) begin
      @(negedge clk);
      if (bus0.mem_en) begin
        en_cyc++;
        check("ws0_mem_addr", bus0.mem_addr, 8'h3C);
      end
      if (bus0.cpu_ack) ack_at = k;
    end
    check("ws0_latency", ack_at, 2);
    check("ws0_en_cycles", en_cyc, 1);
    check("ws0_rdata", bus0.cpu_rdata, 8'h99);
    @(posedge clk);
    #1;
    bus0.cpu_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
